// File: rtl/fifo_ram_ctrl.sv
// FIFO controller owning both ports of a dual-port synchronous RAM: port 0 writes,
// port 1 reads through a FETCH/CAPTURE sequence into a single output register.
module fifo_ram_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_din,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    m_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_WIDTH-1:0]    ram_din_0,
  output logic                     ram_cs_0,
  output logic                     ram_oe_0,
  output logic                     ram_we_0,
  output logic [ADDRESS_WIDTH-1:0] ram_address_0,
  output logic [DATA_WIDTH-1:0]    ram_din_1,
  output logic                     ram_cs_1,
  output logic                     ram_oe_1,
  output logic                     ram_we_1,
  output logic [ADDRESS_WIDTH-1:0] ram_address_1,
  input  logic [DATA_WIDTH-1:0]    ram_dout_1
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_C  = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_LAST = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1);

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr, fetch_addr;
  logic [ADDRESS_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0]    m_dout_q;
  logic                     m_valid_q;
  logic                     wr_en, fetch_en;

  assign full    = (count_q == DEPTH_C);
  assign s_ready = !full;
  assign count   = count_q;
  assign m_dout  = m_dout_q;
  assign m_valid = m_valid_q;
  assign empty   = !m_valid_q;

  // Strobes are gated by rst_n so the RAM sees no access while reset is held.
  assign wr_en    = rst_n && s_valid && s_ready;
  assign fetch_en = rst_n && (state == FETCH);

  always_comb begin
    ram_cs_0      = wr_en;
    ram_we_0      = wr_en;
    ram_oe_0      = 1'b0;
    ram_address_0 = wr_ptr;
    ram_din_0     = s_din;
    ram_cs_1      = fetch_en;
    ram_oe_1      = fetch_en;
    ram_we_1      = 1'b0;
    ram_din_1     = '0;
    // Read data is only valid while the fetched address is still presented.
    ram_address_1 = (state == CAPTURE) ? fetch_addr : rd_ptr;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count_q != '0 && (!m_valid_q || m_ready)) state_next = FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetch_addr <= '0;
      count_q    <= '0;
      m_dout_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (fetch_en) begin
        fetch_addr <= rd_ptr;
        rd_ptr     <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      unique case ({wr_en, fetch_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (state == CAPTURE) begin
        m_dout_q  <= ram_dout_1;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl: behavioural RAM, queue-based reference model
// of the FIFO and its read engine, and scenario tasks with inline comparisons.
module tb_fifo_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n, s_valid, s_ready, m_valid, m_ready, full, empty;
  logic [DW-1:0] s_din, m_dout, ram_din_0, ram_din_1, ram_dout_1;
  logic [AW:0]   count;
  logic          ram_cs_0, ram_oe_0, ram_we_0, ram_cs_1, ram_oe_1, ram_we_1;
  logic [AW-1:0] ram_address_0, ram_address_1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_din(s_din), .s_valid(s_valid), .s_ready(s_ready),
    .m_dout(m_dout), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .full(full), .empty(empty),
    .ram_din_0(ram_din_0), .ram_cs_0(ram_cs_0), .ram_oe_0(ram_oe_0),
    .ram_we_0(ram_we_0), .ram_address_0(ram_address_0),
    .ram_din_1(ram_din_1), .ram_cs_1(ram_cs_1), .ram_oe_1(ram_oe_1),
    .ram_we_1(ram_we_1), .ram_address_1(ram_address_1), .ram_dout_1(ram_dout_1)
  );

  // Synchronous RAM; read data is corrupted if the address moves after the read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  always @(posedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_din_0;
    if (ram_cs_1 && ram_oe_1) begin
      rd_q      <= mem[ram_address_1];
      rd_addr_q <= ram_address_1;
    end
  end
  assign ram_dout_1 = (ram_address_1 == rd_addr_q) ? rd_q : ~rd_q;

  // Reference model: resident entries, read engine stage (0 idle, 1 fetch, 2 capture), output slot.
  logic [DW-1:0] mq[$];
  int            stage = 0;
  logic [DW-1:0] infl;
  bit            ov = 1'b0;
  logic [DW-1:0] od = '0;
  int            rp = 0, fa = 0;

  task automatic tick(output bit acc);
    bit pop, start;
    int old;
    acc   = (rst_n === 1'b1) && s_valid && (mq.size() != DEPTH);
    pop   = ov && m_ready;
    start = (stage == 0) && (mq.size() != 0) && (!ov || m_ready);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      mq.delete(); stage = 0; ov = 1'b0; od = '0; rp = 0; fa = 0; acc = 1'b0;
    end else begin
      old = stage;
      if (old == 2) begin ov = 1'b1; od = infl; end
      else if (pop) ov = 1'b0;
      if (old == 1) begin infl = mq.pop_front(); fa = rp; rp = (rp + 1) % DEPTH; end
      stage = (old == 1) ? 2 : (old == 2) ? 0 : (start ? 1 : 0);
      if (acc) mq.push_back(s_din);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bit a;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    tick(a); tick(a);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit a;
    rst_n = 1'b0; s_valid = 1'b1; s_din = 8'h11; m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(a); #1;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL reset_state s_ready=%b m_valid=%b count=%0d empty=%b want 1 0 0 1",
                 s_ready, m_valid, count, empty);
      end
      checks++;
      if ({ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1} !== 6'b0 || ram_din_1 !== '0) begin
        failures++;
        $display("FAIL reset_strobes got=%b din_1=%h want=000000 din_1=00",
                 {ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_oe_1, ram_we_1}, ram_din_1);
      end
    end
    rst_n = 1'b1; s_din = 8'h3C; #1;
    checks++;
    if ({ram_cs_0, ram_we_0, ram_oe_0} !== 3'b110 || ram_address_0 !== '0 || ram_din_0 !== 8'h3C) begin
      failures++;
      $display("FAIL first_write cs/we/oe=%b addr=%0d din=%h want 110 0 3c",
               {ram_cs_0, ram_we_0, ram_oe_0}, ram_address_0, ram_din_0);
    end
    tick(a); s_valid = 1'b0; #1;
    checks++;
    if (count !== 1) begin failures++; $display("FAIL first_write_count got=%0d want=1", count); end
  endtask

  task automatic test_single_entry();
    bit a;
    apply_reset();
    s_valid = 1'b1; s_din = 8'hA5; m_ready = 1'b1;
    tick(a); s_valid = 1'b0; #1;
    checks++;
    if (count !== 1 || ram_cs_1 !== 1'b0) begin
      failures++; $display("FAIL single_after_write count=%0d cs_1=%b want 1 0", count, ram_cs_1);
    end
    tick(a); #1;
    checks++;
    if ({ram_cs_1, ram_oe_1, ram_we_1} !== 3'b110 || ram_address_1 !== '0 || count !== 1) begin
      failures++;
      $display("FAIL single_fetch cs/oe/we=%b addr=%0d count=%0d want 110 0 1",
               {ram_cs_1, ram_oe_1, ram_we_1}, ram_address_1, count);
    end
    tick(a); #1;
    checks++;
    if (ram_cs_1 !== 1'b0 || ram_address_1 !== '0 || count !== 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_capture cs_1=%b addr=%0d count=%0d m_valid=%b want 0 0 0 0",
               ram_cs_1, ram_address_1, count, m_valid);
    end
    tick(a); #1;
    checks++;
    if (m_valid !== 1'b1 || m_dout !== 8'hA5 || empty !== 1'b0 || count !== 0) begin
      failures++;
      $display("FAIL single_output m_valid=%b m_dout=%h empty=%b count=%0d want 1 a5 0 0",
               m_valid, m_dout, empty, count);
    end
    tick(a); #1;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL single_pop m_valid=%b want 0", m_valid); end
  endtask

  task automatic test_fill();
    bit a;
    int next = 0, accepted = 0, popped = 0;
    apply_reset();
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      s_valid = (next < 10); s_din = DW'(next); #1;
      checks++;
      if (s_ready !== (mq.size() != DEPTH) || count !== (AW+1)'(mq.size()) || m_valid !== ov) begin
        failures++;
        $display("FAIL fill_state cyc=%0d s_ready=%b count=%0d m_valid=%b want %b %0d %b",
                 cyc, s_ready, count, m_valid, mq.size() != DEPTH, mq.size(), ov);
      end
      if (full === 1'b1) begin
        checks++;
        if (ram_cs_0 !== 1'b0 || s_ready !== 1'b0) begin
          failures++; $display("FAIL fill_full_strobe cs_0=%b s_ready=%b want 0 0", ram_cs_0, s_ready);
        end
      end
      tick(a);
      if (a) begin accepted++; next++; end
    end
    s_valid = 1'b0; #1;
    // One entry sits in the output register, so DEPTH+1 writes fit before full.
    checks++;
    if (accepted != DEPTH + 1 || full !== 1'b1 || count !== DEPTH || m_valid !== 1'b1 || m_dout !== 8'h00) begin
      failures++;
      $display("FAIL fill_end accepted=%0d full=%b count=%0d m_valid=%b m_dout=%h want %0d 1 %0d 1 00",
               accepted, full, count, m_valid, m_dout, DEPTH + 1, DEPTH);
    end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && popped < DEPTH + 1; cyc++) begin
      #1;
      if (m_valid === 1'b1) begin
        checks++;
        if (m_dout !== DW'(popped)) begin
          failures++; $display("FAIL fill_drain_data got=%h want=%h", m_dout, DW'(popped));
        end
        popped++;
      end
      tick(a);
    end
    #1;
    checks++;
    if (popped != DEPTH + 1 || m_valid !== 1'b0 || count !== 0) begin
      failures++;
      $display("FAIL fill_drain_end popped=%0d m_valid=%b count=%0d want %0d 0 0",
               popped, m_valid, count, DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    bit a, wrap0 = 1'b0, wrap1 = 1'b0;
    int sent = 0, popped = 0, last0 = -1, last1 = -1;
    logic [DW-1:0] exp_q[$];
    apply_reset();
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && (sent < 20 || popped < 20); cyc++) begin
      s_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      s_din   = DW'($urandom);
      #1;
      if (m_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || m_dout !== exp_q[0]) begin
          failures++; $display("FAIL wrap_order idx=%0d got=%h want=%h", popped, m_dout,
                               (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      checks++;
      if (count !== (AW+1)'(mq.size()) || m_valid !== ov || s_ready !== (mq.size() != DEPTH)) begin
        failures++;
        $display("FAIL wrap_state cyc=%0d count=%0d m_valid=%b s_ready=%b want %0d %b %b",
                 cyc, count, m_valid, s_ready, mq.size(), ov, mq.size() != DEPTH);
      end
      if (stage == 1) begin
        checks++;
        if (ram_cs_1 !== 1'b1 || ram_address_1 !== AW'(rp)) begin
          failures++; $display("FAIL wrap_fetch cs_1=%b addr=%0d want 1 %0d", ram_cs_1, ram_address_1, rp);
        end
      end
      if (ram_cs_0 === 1'b1) begin
        if (last0 == DEPTH - 1 && ram_address_0 == 0) wrap0 = 1'b1;
        last0 = int'(ram_address_0);
      end
      if (ram_cs_1 === 1'b1) begin
        if (last1 == DEPTH - 1 && ram_address_1 == 0) wrap1 = 1'b1;
        last1 = int'(ram_address_1);
      end
      tick(a);
      if (a) begin exp_q.push_back(s_din); sent++; end
    end
    s_valid = 1'b0;
    checks++;
    if (sent != 20 || popped != 20 || !wrap0 || !wrap1) begin
      failures++;
      $display("FAIL wrap_end sent=%0d popped=%0d wrap0=%b wrap1=%b want 20 20 1 1", sent, popped, wrap0, wrap1);
    end
  endtask

  task automatic test_simultaneous();
    bit a;
    apply_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin s_din = DW'(8'h40 + i); tick(a); end
    s_valid = 1'b0; #1;
    checks++;
    if (count !== 3 || m_valid !== 1'b1 || m_dout !== 8'h40) begin
      failures++; $display("FAIL simul_setup count=%0d m_valid=%b m_dout=%h want 3 1 40", count, m_valid, m_dout);
    end
    m_ready = 1'b1; tick(a);
    m_ready = 1'b0; s_valid = 1'b1; s_din = 8'h50; #1;
    checks++;
    if (ram_cs_0 !== 1'b1 || ram_cs_1 !== 1'b1 || count !== 3) begin
      failures++; $display("FAIL simul_strobes cs_0=%b cs_1=%b count=%0d want 1 1 3", ram_cs_0, ram_cs_1, count);
    end
    tick(a); s_valid = 1'b0; #1;
    checks++;
    if (count !== 3 || count !== (AW+1)'(mq.size())) begin
      failures++; $display("FAIL simul_count got=%0d want=3", count);
    end
  endtask

  task automatic test_backpressure();
    bit a;
    int n = 0;
    int rdy_seq[3] = '{0, 0, 1};
    apply_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin s_din = DW'(8'h61 + i); tick(a); end
    s_valid = 1'b0; #1;
    while (m_valid !== 1'b1 && n < 10) begin tick(a); #1; n++; end
    checks++;
    if (m_valid !== 1'b1 || m_dout !== 8'h61) begin
      failures++; $display("FAIL bp_first m_valid=%b m_dout=%h want 1 61", m_valid, m_dout);
    end
    for (int i = 0; i < 3; i++) begin
      m_ready = rdy_seq[i][0]; #1;
      checks++;
      if (m_valid !== 1'b1 || m_dout !== 8'h61 || ram_cs_1 !== 1'b0 || count !== 2) begin
        failures++;
        $display("FAIL bp_hold step=%0d m_valid=%b m_dout=%h cs_1=%b count=%0d want 1 61 0 2",
                 i, m_valid, m_dout, ram_cs_1, count);
      end
      tick(a);
    end
    m_ready = 1'b0; #1;
    checks++;
    if (ram_cs_1 !== 1'b1 || m_valid !== 1'b0 || ram_address_1 !== AW'(1)) begin
      failures++; $display("FAIL bp_fetch cs_1=%b m_valid=%b addr=%0d want 1 0 1", ram_cs_1, m_valid, ram_address_1);
    end
    tick(a);
    rst_n = 1'b0; s_valid = 1'b1; s_din = 8'h77; #1;
    checks++;
    if ({ram_cs_0, ram_we_0, ram_cs_1, ram_oe_1} !== 4'b0) begin
      failures++; $display("FAIL bp_reset_strobes got=%b want=0000", {ram_cs_0, ram_we_0, ram_cs_1, ram_oe_1});
    end
    tick(a);
    rst_n = 1'b1; s_valid = 1'b0; #1;
    checks++;
    if (m_valid !== 1'b0 || count !== 0) begin
      failures++; $display("FAIL bp_reset_state m_valid=%b count=%0d want 0 0", m_valid, count);
    end
    tick(a); #1;
    checks++;
    if (m_valid !== 1'b0 || ram_cs_1 !== 1'b0) begin
      failures++; $display("FAIL bp_after_reset m_valid=%b cs_1=%b want 0 0", m_valid, ram_cs_1);
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_din = '0; m_ready = 1'b0;
    test_reset();
    test_single_entry();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
